// File: rtl/fan_pwm_climate_ctrl_if.sv
// Sensor/mode inputs and fan drive outputs of the climate fan controller.
// The master side is the host/sensor; the slave side is the controller.
interface fan_pwm_climate_ctrl_if #(
  parameter int PWM_BITS = 8
);
  logic [7:0]          temp;
  logic [7:0]          hum;
  logic                sample_valid;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] manual_duty;
  logic                fan_pwm;
  logic                fan_enable;
  logic [PWM_BITS-1:0] duty;
  logic [1:0]          level;
  logic                stale;

  modport master (
    output temp, hum, sample_valid, mode, manual_duty,
    input  fan_pwm, fan_enable, duty, level, stale
  );

  modport slave (
    input  temp, hum, sample_valid, mode, manual_duty,
    output fan_pwm, fan_enable, duty, level, stale
  );
endinterface

// File: rtl/fan_pwm_climate_ctrl.sv
// Four-level fan controller with hysteresis, humidity boost, stale-sensor
// failsafe and a ramped PWM whose duty only changes on period boundaries.
module fan_pwm_climate_ctrl #(
  parameter int PWM_BITS    = 8,
  parameter int PWM_DIV     = 195,
  parameter int T_ON        = 26,
  parameter int T_MID       = 29,
  parameter int T_HIGH      = 32,
  parameter int HYST        = 1,
  parameter int H_MAX       = 80,
  parameter int DUTY_LOW    = 96,
  parameter int DUTY_MID    = 176,
  parameter int DUTY_HIGH   = 255,
  parameter int RAMP_STEP   = 16,
  parameter int TIMEOUT_CYC = 150_000_000
) (
  input logic                  clk,
  input logic                  rst,
  fan_pwm_climate_ctrl_if.slave bus
);
  localparam int PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int STALE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(PWM_DIV - 1);
  localparam logic [STALE_W-1:0]  STALE_MAX = STALE_W'(TIMEOUT_CYC);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_L    = PWM_BITS'(DUTY_LOW);
  localparam logic [PWM_BITS-1:0] DUTY_M    = PWM_BITS'(DUTY_MID);
  localparam logic [PWM_BITS-1:0] DUTY_H    = PWM_BITS'(DUTY_HIGH);

  localparam logic [7:0] TH_ON    = 8'(T_ON);
  localparam logic [7:0] TH_MID   = 8'(T_MID);
  localparam logic [7:0] TH_HIGH  = 8'(T_HIGH);
  // Descent thresholds clamp at 0 so a small threshold never wraps.
  localparam logic [7:0] TH_ON_H   = (T_ON   > HYST) ? 8'(T_ON   - HYST) : 8'd0;
  localparam logic [7:0] TH_MID_H  = (T_MID  > HYST) ? 8'(T_MID  - HYST) : 8'd0;
  localparam logic [7:0] TH_HIGH_H = (T_HIGH > HYST) ? 8'(T_HIGH - HYST) : 8'd0;
  localparam logic [7:0] HUM_MAX   = 8'(H_MAX);

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_OFF    = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;
  localparam logic [1:0] MODE_FULL   = 2'b11;

  typedef enum logic [1:0] {L0, L1, L2, L3} level_t;

  function automatic logic [1:0] count_ge(input logic [7:0] t, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c);
    return {1'b0, t >= a} + {1'b0, t >= b} + {1'b0, t >= c};
  endfunction

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [STALE_W-1:0] sat_inc(input logic [STALE_W-1:0] v);
    return (v == STALE_MAX) ? v : v + 1'b1;
  endfunction

  // Step toward the target by at most RAMP_STEP, never overshooting it.
  function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (tgt > cur) begin
      if (int'(tgt - cur) > RAMP_STEP) return cur + PWM_BITS'(RAMP_STEP);
      return tgt;
    end
    if (int'(cur - tgt) > RAMP_STEP) return cur - PWM_BITS'(RAMP_STEP);
    return tgt;
  endfunction

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, target;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  level_t              level_q, level_d;
  logic                fan_pwm_q, fan_pwm_d;
  logic                fan_en_q, fan_en_d;
  logic                tick, boundary, stale;
  logic [1:0]          up, hold, nxt;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    boundary  = tick && (pwm_cnt_q == DUTY_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    stale       = (stale_cnt_q == STALE_MAX);
    stale_cnt_d = bus.sample_valid ? '0 : sat_inc(stale_cnt_q);

    up   = count_ge(bus.temp, TH_ON, TH_MID, TH_HIGH);
    hold = count_ge(bus.temp, TH_ON_H, TH_MID_H, TH_HIGH_H);
    nxt  = max2(up, min2(level_q, hold));
    if (bus.hum >= HUM_MAX) nxt = max2(nxt, 2'd2);
    level_d = bus.sample_valid ? level_t'(nxt) : level_q;

    target = '0;
    unique case (bus.mode)
      MODE_OFF:    target = '0;
      MODE_FULL:   target = DUTY_MAX;
      MODE_MANUAL: target = bus.manual_duty;
      MODE_AUTO: begin
        if (stale) target = DUTY_H;
        else begin
          unique case (level_q)
            L0: target = '0;
            L1: target = DUTY_L;
            L2: target = DUTY_M;
            L3: target = DUTY_H;
          endcase
        end
      end
    endcase

    // Duty is only reloaded on a period boundary, so no runt pulses.
    duty_d = duty_q;
    if (boundary) duty_d = (bus.mode == MODE_OFF) ? '0 : ramp_toward(duty_q, target);
    fan_en_d  = (duty_d != '0);
    fan_pwm_d = (duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      stale_cnt_q <= '0;
      level_q     <= L0;
      fan_pwm_q   <= 1'b0;
      fan_en_q    <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      stale_cnt_q <= stale_cnt_d;
      level_q     <= level_d;
      fan_pwm_q   <= fan_pwm_d;
      fan_en_q    <= fan_en_d;
    end
  end

  assign bus.fan_pwm    = fan_pwm_q;
  assign bus.fan_enable = fan_en_q;
  assign bus.duty       = duty_q;
  assign bus.level      = level_q;
  assign bus.stale      = stale;
endmodule

// File: tb/tb_fan_pwm_climate_ctrl.sv
// Scoreboard bench for fan_pwm_climate_ctrl: stimulus queues expectations,
// a single monitor process compares them against the DUT outputs.
module tb_fan_pwm_climate_ctrl;
  localparam int PB = 4;
  localparam int SEL_LEVEL = 0, SEL_DUTY = 1, SEL_PWM = 2, SEL_EN = 3, SEL_STALE = 4, SEL_WIN = 5;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  int   ecnt = 0;
  bit   done = 1'b0;
  int   errors = 0;
  int   checks = 0;
  chk_t snap_q[$];
  int   dseq[$];

  always #5 clk = ~clk;

  fan_pwm_climate_ctrl_if #(.PWM_BITS(PB)) ifc();

  fan_pwm_climate_ctrl #(
    .PWM_BITS(PB), .PWM_DIV(2), .RAMP_STEP(4), .TIMEOUT_CYC(100),
    .DUTY_LOW(4), .DUTY_MID(10), .DUTY_HIGH(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // Cycles since reset release; a PWM period is 16 ticks x 2 clocks = 32.
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input int sel, input int val);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.val  = val;
    snap_q.push_back(c);
  endtask

  task automatic strobe(input int t, input int h);
    ifc.temp = 8'(t);
    ifc.hum  = 8'(h);
    ifc.sample_valid = 1'b1;
    tick(1);
    ifc.sample_valid = 1'b0;
  endtask

  task automatic wait_duty(input int val, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(ifc.duty) == val) begin
        hit = 1'b1;
        break;
      end
    end
    tick(1);
    if (!hit) expect_now("wait_duty_timeout", SEL_DUTY, val);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 64; i++) begin
      if (ecnt % 32 == p) break;
      tick(1);
    end
  endtask

  function automatic int actual(input int sel);
    case (sel)
      SEL_LEVEL: return int'(ifc.level);
      SEL_DUTY:  return int'(ifc.duty);
      SEL_PWM:   return int'(ifc.fan_pwm);
      SEL_EN:    return int'(ifc.fan_enable);
      SEL_STALE: return int'(ifc.stale);
      default:   return -1;
    endcase
  endfunction

  // Monitor: duty-change scoreboard, snapshot checks and PWM high-count windows.
  initial begin
    int    prev_duty = 0;
    int    win_left  = 0;
    int    win_hi    = 0;
    int    win_exp   = 0;
    string win_name  = "";
    chk_t  c;
    int    a;
    forever begin
      @(negedge clk);
      if (int'(ifc.duty) != prev_duty) begin
        checks++;
        if (dseq.size() == 0) begin
          errors++;
          $display("FAIL duty_seq: unexpected change to %0d, expected none", ifc.duty);
        end else begin
          a = dseq.pop_front();
          if (int'(ifc.duty) != a) begin
            errors++;
            $display("FAIL duty_seq: got %0d, expected %0d", ifc.duty, a);
          end
        end
        if (!rst) begin
          checks++;
          if (ecnt == 0 || ecnt % 32 != 0) begin
            errors++;
            $display("FAIL duty_boundary: change at cycle %0d, required a multiple of 32", ecnt);
          end
        end
      end
      prev_duty = int'(ifc.duty);

      while (win_left == 0 && snap_q.size() > 0) begin
        c = snap_q.pop_front();
        if (c.sel == SEL_WIN) begin
          win_left = 32;
          win_hi   = 0;
          win_exp  = c.val;
          win_name = c.name;
        end else begin
          checks++;
          a = actual(c.sel);
          if (a != c.val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", c.name, a, c.val);
          end
        end
      end

      if (win_left > 0) begin
        win_hi += int'(ifc.fan_pwm);
        win_left--;
        if (win_left == 0) begin
          checks++;
          if (win_hi != win_exp) begin
            errors++;
            $display("FAIL %s: got %0d high cycles, expected %0d", win_name, win_hi, win_exp);
          end
        end
      end

      if (done) begin
        checks++;
        if (snap_q.size() != 0) begin
          errors++;
          $display("FAIL snap_drain: got %0d pending, expected 0", snap_q.size());
        end
        checks++;
        if (dseq.size() != 0) begin
          errors++;
          $display("FAIL duty_seq_drain: got %0d pending, expected 0", dseq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw_t[6] = '{32, 31, 30, 28, 27, 24};
    int sw_l[6] = '{3, 3, 2, 2, 1, 0};
    rst = 1'b1;
    ifc.temp = '0;
    ifc.hum = '0;
    ifc.sample_valid = 1'b0;
    ifc.mode = 2'b00;
    ifc.manual_duty = '0;
    tick(3);
    expect_now("rst_level", SEL_LEVEL, 0);
    expect_now("rst_duty", SEL_DUTY, 0);
    expect_now("rst_pwm", SEL_PWM, 0);
    expect_now("rst_enable", SEL_EN, 0);
    expect_now("rst_stale", SEL_STALE, 0);
    rst = 1'b0;

    // Cool room: fan stays off.
    strobe(25, 50);
    expect_now("cool_level", SEL_LEVEL, 0);
    tick(40);
    expect_now("cool_duty", SEL_DUTY, 0);
    expect_now("cool_enable", SEL_EN, 0);
    expect_now("cool_pwm_window", SEL_WIN, 0);
    tick(34);

    // Hot: jump to level 3 and ramp to full.
    dseq.push_back(4); dseq.push_back(8); dseq.push_back(12); dseq.push_back(15);
    strobe(33, 50);
    expect_now("hot_level", SEL_LEVEL, 3);
    wait_duty(15, 200);
    expect_now("hot_enable", SEL_EN, 1);
    expect_now("full_pwm_window", SEL_WIN, 32);
    tick(34);

    // Hysteresis sweep then humidity boost; duty settles at DUTY_MID.
    dseq.push_back(11); dseq.push_back(10);
    for (int i = 0; i < 6; i++) begin
      strobe(sw_t[i], 50);
      expect_now($sformatf("hyst_t%0d", sw_t[i]), SEL_LEVEL, sw_l[i]);
    end
    strobe(20, 85);
    expect_now("humid_boost", SEL_LEVEL, 2);
    wait_duty(10, 200);
    strobe(20, 85);
    expect_now("humid_hold", SEL_LEVEL, 2);
    expect_now("mid_pwm_window", SEL_WIN, 20);
    tick(34);

    // Stale timeout forces full duty.
    strobe(20, 85);
    tick(99);
    expect_now("stale_pre", SEL_STALE, 0);
    tick(1);
    expect_now("stale_assert", SEL_STALE, 1);
    dseq.push_back(14); dseq.push_back(15);
    wait_duty(15, 200);
    expect_now("stale_hold", SEL_STALE, 1);
    strobe(33, 50);
    expect_now("stale_clear", SEL_STALE, 0);
    expect_now("stale_clear_level", SEL_LEVEL, 3);
    tick(99);
    expect_now("sat_edge_pre", SEL_STALE, 0);
    strobe(33, 50);
    expect_now("sat_clear_wins", SEL_STALE, 0);
    tick(1);
    expect_now("sat_clear_after", SEL_STALE, 0);

    // Manual mode selected mid-period.
    dseq.push_back(11); dseq.push_back(7); dseq.push_back(6);
    wait_phase(16);
    ifc.mode = 2'b10;
    ifc.manual_duty = 4'd6;
    wait_phase(31);
    expect_now("manual_no_early", SEL_DUTY, 15);
    wait_duty(6, 200);
    expect_now("manual_pwm_window", SEL_WIN, 12);
    tick(34);

    // Off mode: immediate drop at the next boundary.
    dseq.push_back(0);
    wait_phase(10);
    ifc.mode = 2'b01;
    wait_phase(31);
    expect_now("off_no_early", SEL_DUTY, 6);
    wait_duty(0, 100);
    expect_now("off_enable", SEL_EN, 0);
    expect_now("off_pwm_window", SEL_WIN, 0);
    tick(34);

    // Reset in the middle of a full-mode ramp.
    ifc.mode = 2'b11;
    dseq.push_back(4); dseq.push_back(8);
    wait_duty(8, 200);
    wait_phase(3);
    expect_now("pre_reset_pwm", SEL_PWM, 1);
    expect_now("pre_reset_level", SEL_LEVEL, 3);
    rst = 1'b1;
    dseq.push_back(0);
    tick(1);
    expect_now("rst_mid_duty", SEL_DUTY, 0);
    expect_now("rst_mid_pwm", SEL_PWM, 0);
    expect_now("rst_mid_enable", SEL_EN, 0);
    expect_now("rst_mid_level", SEL_LEVEL, 0);
    expect_now("rst_mid_stale", SEL_STALE, 0);
    tick(2);
    rst = 1'b0;
    dseq.push_back(4); dseq.push_back(8); dseq.push_back(12); dseq.push_back(15);
    wait_duty(15, 200);
    tick(3);
    done = 1'b1;
  end
endmodule
